// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and ALU encodings for the ID stage.
package id_stage_pipe_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpPref    = 6'h33;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnSync = 6'h0f;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;

  typedef enum logic [7:0] {
    AluNop  = 8'h00,
    AluSrl  = 8'h02,
    AluSra  = 8'h03,
    AluSllv = 8'h04,
    AluSrlv = 8'h06,
    AluSrav = 8'h07,
    AluAnd  = 8'h24,
    AluOr   = 8'h25,
    AluXor  = 8'h26,
    AluNor  = 8'h27,
    AluSll  = 8'h7c
  } alu_op_e;

  typedef enum logic [2:0] {
    SelNop   = 3'b000,
    SelLogic = 3'b001,
    SelShift = 3'b010
  } alu_sel_e;

endpackage

// File: rtl/id_fwd_sel.sv
// Operand resolver: immediate, r0, youngest matching forward port, else regfile data.
module id_fwd_sel
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic                        re_i,
  input  logic [REG_AW-1:0]           ra_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [DATA_W-1:0]           rf_rd_i,
  input  logic [FWD_PORTS-1:0]        fwd_we_i,
  input  logic [FWD_PORTS-1:0]        fwd_pend_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        pend_o
);

  always_comb begin
    data_o = rf_rd_i;
    pend_o = 1'b0;
    if (!re_i) begin
      data_o = imm_i;
    end else if (ra_i == '0) begin
      data_o = '0;
    end else begin
      // Walk oldest to youngest so the lowest matching index wins.
      for (int i = int'(FWD_PORTS) - 1; i >= 0; i--) begin
        if (fwd_we_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == ra_i) begin
          data_o = fwd_data_i[i*DATA_W +: DATA_W];
          pend_o = fwd_pend_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with registered ID/EX boundary, forwarding and load-hazard stall.
// Optional ID_ILLEGAL_EN adds the registered illegal-instruction flag.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_PORTS = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  input  logic                        flush_i,
  output logic                        rf_re1_o,
  output logic                        rf_re2_o,
  output logic [REG_AW-1:0]           rf_ra1_o,
  output logic [REG_AW-1:0]           rf_ra2_o,
  input  logic [DATA_W-1:0]           rf_rd1_i,
  input  logic [DATA_W-1:0]           rf_rd2_i,
  input  logic [FWD_PORTS-1:0]        fwd_we_i,
  input  logic [FWD_PORTS-1:0]        fwd_pend_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [31:0]                 out_pc_o,
  output alu_op_e                     alu_op_o,
  output alu_sel_e                    alu_sel_o,
  output logic [DATA_W-1:0]           src1_o,
  output logic [DATA_W-1:0]           src2_o,
  output logic [REG_AW-1:0]           des_addr_o,
  output logic                        des_exist_o,
  output logic                        illegal_o
);

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign opc   = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  alu_op_e           dec_op;
  alu_sel_e          dec_sel;
  logic              dec_re1, dec_re2, dec_we;
  logic [4:0]        dec_waddr;
  logic [DATA_W-1:0] dec_imm;
`ifdef ID_ILLEGAL_EN
  logic              dec_ill;
`endif

  always_comb begin
    dec_op    = AluNop;
    dec_sel   = SelNop;
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_we    = 1'b0;
    dec_waddr = '0;
    dec_imm   = '0;
`ifdef ID_ILLEGAL_EN
    dec_ill   = 1'b0;
`endif
    case (opc)
      OpSpecial: begin
        if (inst_i[31:21] == 11'd0 && (fn == FnSll || fn == FnSrl || fn == FnSra)) begin
          dec_re2   = 1'b1;
          dec_we    = 1'b1;
          dec_waddr = rd;
          dec_sel   = SelShift;
          dec_imm   = DATA_W'(sa);
          case (fn)
            FnSll:   dec_op = AluSll;
            FnSrl:   dec_op = AluSrl;
            default: dec_op = AluSra;
          endcase
        end else if (sa != 5'd0) begin
`ifdef ID_ILLEGAL_EN
          dec_ill = 1'b1;
`endif
        end else begin
          dec_re1   = 1'b1;
          dec_re2   = 1'b1;
          dec_we    = 1'b1;
          dec_waddr = rd;
          case (fn)
            FnAnd:  begin dec_op = AluAnd;  dec_sel = SelLogic; end
            FnOr:   begin dec_op = AluOr;   dec_sel = SelLogic; end
            FnXor:  begin dec_op = AluXor;  dec_sel = SelLogic; end
            FnNor:  begin dec_op = AluNor;  dec_sel = SelLogic; end
            FnSllv: begin dec_op = AluSllv; dec_sel = SelShift; end
            FnSrlv: begin dec_op = AluSrlv; dec_sel = SelShift; end
            FnSrav: begin dec_op = AluSrav; dec_sel = SelShift; end
            default: begin
              // sync and unknown functs both retire as a nop
              dec_re1   = 1'b0;
              dec_re2   = 1'b0;
              dec_we    = 1'b0;
              dec_waddr = '0;
`ifdef ID_ILLEGAL_EN
              dec_ill   = (fn != FnSync);
`endif
            end
          endcase
        end
      end
      OpAndi, OpOri, OpXori: begin
        dec_re1   = 1'b1;
        dec_we    = 1'b1;
        dec_waddr = rt;
        dec_sel   = SelLogic;
        dec_imm   = DATA_W'(imm16);
        case (opc)
          OpAndi:  dec_op = AluAnd;
          OpOri:   dec_op = AluOr;
          default: dec_op = AluXor;
        endcase
      end
      OpLui: begin
        dec_re1   = 1'b1;
        dec_we    = 1'b1;
        dec_waddr = rt;
        dec_sel   = SelLogic;
        dec_op    = AluOr;
        dec_imm   = DATA_W'({imm16, 16'h0000});
      end
      OpPref: ;
      default: begin
`ifdef ID_ILLEGAL_EN
        dec_ill = 1'b1;
`endif
      end
    endcase
  end

  assign rf_re1_o = dec_re1;
  assign rf_re2_o = dec_re2;
  assign rf_ra1_o = REG_AW'(rs);
  assign rf_ra2_o = REG_AW'(rt);

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              pend1, pend2;

  id_fwd_sel #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .FWD_PORTS(FWD_PORTS)
  ) u_sel1 (
    .re_i      (dec_re1),
    .ra_i      (rf_ra1_o),
    .imm_i     (dec_imm),
    .rf_rd_i   (rf_rd1_i),
    .fwd_we_i  (fwd_we_i),
    .fwd_pend_i(fwd_pend_i),
    .fwd_addr_i(fwd_addr_i),
    .fwd_data_i(fwd_data_i),
    .data_o    (opnd1),
    .pend_o    (pend1)
  );

  id_fwd_sel #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .FWD_PORTS(FWD_PORTS)
  ) u_sel2 (
    .re_i      (dec_re2),
    .ra_i      (rf_ra2_o),
    .imm_i     (dec_imm),
    .rf_rd_i   (rf_rd2_i),
    .fwd_we_i  (fwd_we_i),
    .fwd_pend_i(fwd_pend_i),
    .fwd_addr_i(fwd_addr_i),
    .fwd_data_i(fwd_data_i),
    .data_o    (opnd2),
    .pend_o    (pend2)
  );

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  alu_op_e           op_q, op_d;
  alu_sel_e          sel_q, sel_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [REG_AW-1:0] daddr_q, daddr_d;
  logic              dexist_q, dexist_d;
  logic              hz, adv, accept;

  assign hz         = pend1 | pend2;
  assign adv        = ~valid_q | out_ready_i;
  // A flush drops the offered op, so the stage may always take it that cycle.
  assign in_ready_o = rst_ni & (flush_i | (~hz & adv));
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    op_d     = op_q;
    sel_d    = sel_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    daddr_d  = daddr_q;
    dexist_d = dexist_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      pc_d     = pc_i;
      op_d     = dec_op;
      sel_d    = dec_sel;
      src1_d   = opnd1;
      src2_d   = opnd2;
      daddr_d  = REG_AW'(dec_waddr);
      dexist_d = dec_we & (dec_waddr != 5'd0);
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      op_q     <= AluNop;
      sel_q    <= SelNop;
      src1_q   <= '0;
      src2_q   <= '0;
      daddr_q  <= '0;
      dexist_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      daddr_q  <= daddr_d;
      dexist_q <= dexist_d;
    end
  end

`ifdef ID_ILLEGAL_EN
  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if (!flush_i && accept) ill_d = dec_ill;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ill_q <= 1'b0;
    else         ill_q <= ill_d;
  end

  assign illegal_o = ill_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign out_valid_o = valid_q;
  assign out_pc_o    = pc_q;
  assign alu_op_o    = op_q;
  assign alu_sel_o   = sel_q;
  assign src1_o      = src1_q;
  assign src2_o      = src2_q;
  assign des_addr_o  = daddr_q;
  assign des_exist_o = dexist_q;

endmodule
